// File: rtl/cv_ctrl_mux.sv
// Console controller port multiplexer: turns host joystick words into the
// active-low port lines (keypad/joystick segments, fire) and synthesises
// spinner quadrature plus a shared spinner interrupt.
// Ports:
//   clk_i, reset_n_i, clk_en_i  - clock, async active-low reset, 10.7 MHz enable
//   joy_i, swap_i               - per-port 32-bit joystick words, port 0/1 swap
//   spin_delta_i, spin_valid_i  - signed spinner deltas and their strobes
//   sel_kp_n_i, sel_joy_n_i     - console segment selects (active low)
//   data_n_o, fire_n_o          - port lines p1..p4 and p6 (active low)
//   quad_a_o, quad_b_o          - spinner phases (p7, p9)
//   spin_int_n_o                - wired-AND spinner interrupt (active low)
module cv_ctrl_mux #(
  parameter int unsigned NUM_PORTS = 2,
  parameter logic [15:0] TURBO_DIV = 16'd44744,
  parameter logic [11:0] SPIN_DIV  = 12'd1070,
  parameter logic [7:0]  INT_LEN   = 8'd64
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   clk_en_i,
  input  logic [NUM_PORTS*32-1:0] joy_i,
  input  logic                   swap_i,
  input  logic [NUM_PORTS*8-1:0] spin_delta_i,
  input  logic [NUM_PORTS-1:0]   spin_valid_i,
  input  logic [NUM_PORTS-1:0]   sel_kp_n_i,
  input  logic [NUM_PORTS-1:0]   sel_joy_n_i,
  output logic [NUM_PORTS*4-1:0] data_n_o,
  output logic [NUM_PORTS-1:0]   fire_n_o,
  output logic [NUM_PORTS-1:0]   quad_a_o,
  output logic [NUM_PORTS-1:0]   quad_b_o,
  output logic                   spin_int_n_o
);

  localparam int unsigned JOY_W  = 22;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned SUM_W  = 11;

  // Keypad code for the highest-priority key held in a joystick word.
  function automatic logic [3:0] kp_code(input logic [JOY_W-1:0] j);
    logic [3:0] c;
    c = 4'b1111;
    if      (j[8])  c = 4'b0011;
    else if (j[9])  c = 4'b1110;
    else if (j[10]) c = 4'b1101;
    else if (j[11]) c = 4'b0110;
    else if (j[12]) c = 4'b0001;
    else if (j[13]) c = 4'b1001;
    else if (j[14]) c = 4'b0111;
    else if (j[15]) c = 4'b1100;
    else if (j[16]) c = 4'b1000;
    else if (j[17]) c = 4'b1011;
    else if (j[6])  c = 4'b1010;
    else if (j[7])  c = 4'b0101;
    else if (j[18]) c = 4'b0100;
    else if (j[19]) c = 4'b0010;
    return c;
  endfunction

  logic [JOY_W-1:0]        joy_sw   [NUM_PORTS];
  logic [JOY_W-1:0]        joy_q    [NUM_PORTS];
  logic signed [ACC_W-1:0] acc_q    [NUM_PORTS];
  logic signed [ACC_W-1:0] acc_nxt  [NUM_PORTS];
  logic signed [SUM_W-1:0] sum_c    [NUM_PORTS];
  logic [11:0]             timer_q  [NUM_PORTS];
  logic [11:0]             timer_nxt[NUM_PORTS];
  logic [1:0]              phase_q  [NUM_PORTS];
  logic [1:0]              phase_nxt[NUM_PORTS];
  logic [7:0]              int_q    [NUM_PORTS];
  logic [7:0]              int_nxt  [NUM_PORTS];
  logic [NUM_PORTS-1:0]    step_c;
  logic [NUM_PORTS*4-1:0]  data_nxt;
  logic [NUM_PORTS-1:0]    fire_nxt;
  logic                    int_any_nxt;
  logic [15:0]             turbo_cnt;
  logic                    turbo_phase;
  int unsigned             src;
  logic                    unused_joy_hi;

  // Upper joystick word bits carry no function on this console.
  always_comb begin
    unused_joy_hi = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      unused_joy_hi = unused_joy_hi ^ (^joy_i[p*32+JOY_W +: 32-JOY_W]);
    end
  end

  // Port 0/1 source exchange; single-port builds never swap.
  always_comb begin
    src = 0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      src = p;
      if ((NUM_PORTS > 1) && swap_i && (p < 2)) src = p ^ 32'd1;
      joy_sw[p] = joy_i[src*32 +: JOY_W];
    end
  end

  // Segment decode and fire combine from registered joystick words.
  always_comb begin
    data_nxt = '1;
    fire_nxt = '1;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      data_nxt[p*4 +: 4] = (sel_kp_n_i[p]  ? 4'b1111 : kp_code(joy_q[p])) &
                           (sel_joy_n_i[p] ? 4'b1111 : ~joy_q[p][3:0]);
      fire_nxt[p] = (~(joy_q[p][5] | (joy_q[p][21] & turbo_phase)) | sel_kp_n_i[p]) &
                    (~(joy_q[p][4] | (joy_q[p][20] & turbo_phase)) | sel_joy_n_i[p]);
    end
  end

  // Spinner: accumulate deltas, drain one quadrature step per timer period.
  // A delta arriving on a step cycle is merged so neither update is lost.
  always_comb begin
    int_any_nxt = 1'b0;
    step_c      = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      step_c[p] = clk_en_i && (acc_q[p] != '0) && (timer_q[p] == SPIN_DIV - 12'd1);

      sum_c[p] = SUM_W'(acc_q[p]);
      if (spin_valid_i[p]) sum_c[p] = sum_c[p] + SUM_W'($signed(spin_delta_i[p*8 +: 8]));
      if (step_c[p]) sum_c[p] = acc_q[p][ACC_W-1] ? sum_c[p] + 11'sd1 : sum_c[p] - 11'sd1;

      if (sum_c[p] > 11'sd511)        acc_nxt[p] = 10'sd511;
      else if (sum_c[p] < -11'sd512)  acc_nxt[p] = -10'sd512;
      else                            acc_nxt[p] = sum_c[p][ACC_W-1:0];

      phase_nxt[p] = phase_q[p];
      if (step_c[p]) phase_nxt[p] = acc_q[p][ACC_W-1] ? phase_q[p] - 2'd1 : phase_q[p] + 2'd1;

      // Timer saturates one tick short of expiry so an idle port steps promptly.
      timer_nxt[p] = timer_q[p];
      if (step_c[p])                                            timer_nxt[p] = '0;
      else if (clk_en_i && (timer_q[p] != SPIN_DIV - 12'd1))   timer_nxt[p] = timer_q[p] + 12'd1;

      int_nxt[p] = int_q[p];
      if (step_c[p])                          int_nxt[p] = INT_LEN;
      else if (clk_en_i && (int_q[p] != '0))  int_nxt[p] = int_q[p] - 8'd1;

      if (int_nxt[p] != '0) int_any_nxt = 1'b1;
    end
  end

  // Shared autofire phase.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (clk_en_i) begin
      if (turbo_cnt == TURBO_DIV - 16'd1) begin
        turbo_cnt   <= '0;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + 16'd1;
      end
    end
  end

  // Per-port state and all registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_n_o     <= '1;
      fire_n_o     <= '1;
      quad_a_o     <= '1;
      quad_b_o     <= '1;
      spin_int_n_o <= 1'b1;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        joy_q[p]   <= '0;
        acc_q[p]   <= '0;
        timer_q[p] <= '0;
        phase_q[p] <= '0;
        int_q[p]   <= '0;
      end
    end else begin
      data_n_o     <= data_nxt;
      fire_n_o     <= fire_nxt;
      spin_int_n_o <= ~int_any_nxt;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        joy_q[p]    <= joy_sw[p];
        acc_q[p]    <= acc_nxt[p];
        timer_q[p]  <= timer_nxt[p];
        phase_q[p]  <= phase_nxt[p];
        int_q[p]    <= int_nxt[p];
        // {a,b}: phase 0=11, 1=01, 2=00, 3=10
        quad_a_o[p] <= ~(phase_nxt[p][0] ^ phase_nxt[p][1]);
        quad_b_o[p] <= ~phase_nxt[p][1];
      end
    end
  end

endmodule

// File: tb/tb_cv_ctrl_mux.sv
// Directed bench for cv_ctrl_mux: keypad/joystick vector table plus
// hand-written turbo, spinner and reset sequences.
module tb_cv_ctrl_mux;

  localparam int unsigned NP = 2;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic            clk_en_i;
  logic [NP*32-1:0] joy_i;
  logic            swap_i;
  logic [NP*8-1:0] spin_delta_i;
  logic [NP-1:0]   spin_valid_i;
  logic [NP-1:0]   sel_kp_n_i;
  logic [NP-1:0]   sel_joy_n_i;
  logic [NP*4-1:0] data_n_o;
  logic [NP-1:0]   fire_n_o;
  logic [NP-1:0]   quad_a_o;
  logic [NP-1:0]   quad_b_o;
  logic            spin_int_n_o;

  always #5 clk_i = ~clk_i;

  cv_ctrl_mux #(
    .NUM_PORTS(NP), .TURBO_DIV(16'd4), .SPIN_DIV(12'd2), .INT_LEN(8'd8)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clk_en_i(clk_en_i),
    .joy_i(joy_i), .swap_i(swap_i),
    .spin_delta_i(spin_delta_i), .spin_valid_i(spin_valid_i),
    .sel_kp_n_i(sel_kp_n_i), .sel_joy_n_i(sel_joy_n_i),
    .data_n_o(data_n_o), .fire_n_o(fire_n_o),
    .quad_a_o(quad_a_o), .quad_b_o(quad_b_o), .spin_int_n_o(spin_int_n_o)
  );

  typedef struct {
    logic [31:0] j0;
    logic [31:0] j1;
    logic        sw;
    logic [1:0]  kp;
    logic [1:0]  js;
    logic [7:0]  d;
    logic [1:0]  f;
  } vec_t;

  vec_t vt[19];
  int n_total = 0;
  int n_pass  = 0;

  logic [1:0] ab_seq[8];
  int sp_ntr, sp_gap, sp_low;
  int tg_ntr, tg_gap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic reset_dut();
    reset_n_i    = 1'b0;
    spin_valid_i = '0;
    cyc(2);
    reset_n_i = 1'b1;
  endtask

  task automatic pulse0(input logic [7:0] d);
    spin_delta_i[7:0] = d;
    spin_valid_i[0]   = 1'b1;
    cyc(1);
    spin_valid_i[0]   = 1'b0;
  endtask

  // Toggle intervals of fire_n_o[0] over n samples.
  task automatic count_toggles(input int n);
    logic prev;
    int last;
    prev = fire_n_o[0];
    last = -1;
    tg_ntr = 0;
    tg_gap = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (fire_n_o[0] !== prev) begin
        if (last >= 0 && (i - last) != 4) tg_gap++;
        last = i;
        tg_ntr++;
        prev = fire_n_o[0];
      end
    end
  endtask

  // Fresh reset, one delta on port 0, then record quadrature changes.
  task automatic spin_run(input logic [7:0] d);
    logic [1:0] prev, ab;
    int last;
    reset_dut();
    clk_en_i = 1'b1;
    cyc(4);
    pulse0(d);
    prev = 2'b11;
    last = -1;
    sp_ntr = 0;
    sp_gap = 0;
    sp_low = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      ab = {quad_a_o[0], quad_b_o[0]};
      if (ab !== prev) begin
        if (sp_ntr < 8) ab_seq[sp_ntr] = ab;
        if (last >= 0 && (i - last) != 2) sp_gap++;
        last = i;
        sp_ntr++;
        prev = ab;
      end
      if (spin_int_n_o === 1'b0) sp_low++;
    end
  endtask

  initial begin
    int k, bad;
    vt[0]  = '{32'h0,      32'h0,      1'b0, 2'b11, 2'b11, 8'hFF, 2'b11};
    vt[1]  = '{32'h1100,   32'h0,      1'b0, 2'b10, 2'b11, 8'hF3, 2'b11};
    vt[2]  = '{32'h200,    32'h0,      1'b0, 2'b10, 2'b11, 8'hFE, 2'b11};
    vt[3]  = '{32'h20000,  32'h0,      1'b0, 2'b10, 2'b11, 8'hFB, 2'b11};
    vt[4]  = '{32'h40,     32'h0,      1'b0, 2'b10, 2'b11, 8'hFA, 2'b11};
    vt[5]  = '{32'h80,     32'h0,      1'b0, 2'b10, 2'b11, 8'hF5, 2'b11};
    vt[6]  = '{32'h40000,  32'h0,      1'b0, 2'b10, 2'b11, 8'hF4, 2'b11};
    vt[7]  = '{32'h80000,  32'h0,      1'b0, 2'b10, 2'b11, 8'hF2, 2'b11};
    vt[8]  = '{32'hC00,    32'h0,      1'b0, 2'b10, 2'b11, 8'hFD, 2'b11};
    vt[9]  = '{32'h218,    32'h0,      1'b0, 2'b10, 2'b10, 8'hF6, 2'b10};
    vt[10] = '{32'h3,      32'h0,      1'b0, 2'b11, 2'b10, 8'hFC, 2'b11};
    vt[11] = '{32'h20,     32'h0,      1'b0, 2'b11, 2'b10, 8'hFF, 2'b11};
    vt[12] = '{32'h20,     32'h0,      1'b0, 2'b10, 2'b11, 8'hFF, 2'b10};
    vt[13] = '{32'h3FFFFF, 32'h3FFFFF, 1'b0, 2'b11, 2'b11, 8'hFF, 2'b11};
    vt[14] = '{32'h4,      32'h0,      1'b0, 2'b11, 2'b10, 8'hFB, 2'b11};
    vt[15] = '{32'h8,      32'h200,    1'b1, 2'b10, 2'b01, 8'h7E, 2'b11};
    vt[16] = '{32'h8,      32'h200,    1'b0, 2'b10, 2'b01, 8'hFF, 2'b11};
    vt[17] = '{32'h0,      32'h1000,   1'b0, 2'b01, 2'b11, 8'h1F, 2'b11};
    vt[18] = '{32'h0,      32'h10,     1'b0, 2'b11, 2'b01, 8'hFF, 2'b01};

    reset_n_i    = 1'b0;
    clk_en_i     = 1'b1;
    joy_i        = '0;
    swap_i       = 1'b0;
    spin_delta_i = '0;
    spin_valid_i = '0;
    sel_kp_n_i   = '1;
    sel_joy_n_i  = '1;

    // Reset state
    cyc(2);
    check("rst_data", {24'b0, data_n_o}, 32'hFF);
    check("rst_fire", {30'b0, fire_n_o}, 32'h3);
    check("rst_quad", {28'b0, quad_a_o, quad_b_o}, 32'hF);
    check("rst_int",  {31'b0, spin_int_n_o}, 32'h1);
    reset_n_i = 1'b1;
    cyc(3);

    // Segment decode table
    for (int i = 0; i < 19; i++) begin
      joy_i       = {vt[i].j1, vt[i].j0};
      swap_i      = vt[i].sw;
      sel_kp_n_i  = vt[i].kp;
      sel_joy_n_i = vt[i].js;
      cyc(3);
      check($sformatf("vec%0d_data", i), {24'b0, data_n_o}, {24'b0, vt[i].d});
      check($sformatf("vec%0d_fire", i), {30'b0, fire_n_o}, {30'b0, vt[i].f});
    end
    swap_i = 1'b0;

    // Latency: one clock from select, two from joystick word
    joy_i = {32'h0, 32'h1100};
    sel_kp_n_i = 2'b11;
    sel_joy_n_i = 2'b11;
    cyc(3);
    sel_kp_n_i = 2'b10;
    cyc(1);
    check("lat_sel", {24'b0, data_n_o}, 32'hF3);
    joy_i = {32'h0, 32'h200};
    cyc(1);
    check("lat_joy1", {24'b0, data_n_o}, 32'hF3);
    cyc(1);
    check("lat_joy2", {24'b0, data_n_o}, 32'hFE);

    // Turbo fire on port 0 joystick segment
    reset_dut();
    joy_i = {32'h0, 32'h100000};
    sel_kp_n_i = 2'b11;
    sel_joy_n_i = 2'b10;
    cyc(3);
    count_toggles(40);
    check("turbo_gap", tg_gap, 0);
    check("turbo_toggles", (tg_ntr >= 8) ? 1 : 0, 1);
    clk_en_i = 1'b0;
    cyc(1);
    count_toggles(12);
    check("turbo_frozen", tg_ntr, 0);
    clk_en_i = 1'b1;
    joy_i = {32'h0, 32'h100010};
    cyc(3);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      if (fire_n_o[0] !== 1'b0) bad++;
    end
    check("turbo_plus_fire", bad, 0);
    joy_i = '0;
    sel_joy_n_i = 2'b11;

    // Spinner +3: phases 1,2,3 two ticks apart
    spin_run(8'd3);
    check("sp3_steps", sp_ntr, 3);
    check("sp3_ab0", {30'b0, ab_seq[0]}, 32'h1);
    check("sp3_ab1", {30'b0, ab_seq[1]}, 32'h0);
    check("sp3_ab2", {30'b0, ab_seq[2]}, 32'h2);
    check("sp3_gap", sp_gap, 0);
    check("sp3_int_low", sp_low, 12);
    check("sp3_acc", {22'b0, dut.acc_q[0]}, 32'h0);
    check("sp3_int_end", {31'b0, spin_int_n_o}, 32'h1);

    // Spinner -2: phases 3,2
    spin_run(8'hFE);
    check("spm2_steps", sp_ntr, 2);
    check("spm2_ab0", {30'b0, ab_seq[0]}, 32'h2);
    check("spm2_ab1", {30'b0, ab_seq[1]}, 32'h0);
    check("spm2_int_low", sp_low, 10);

    // Accumulator saturation with steps frozen
    reset_dut();
    clk_en_i = 1'b1;
    cyc(3);
    clk_en_i = 1'b0;
    repeat (4) pulse0(8'd127);
    pulse0(8'd2);
    check("acc_510", {22'b0, dut.acc_q[0]}, {22'b0, 10'h1FE});
    pulse0(8'd127);
    check("acc_sat_pos", {22'b0, dut.acc_q[0]}, {22'b0, 10'h1FF});
    repeat (8) pulse0(8'h80);
    check("acc_sat_neg", {22'b0, dut.acc_q[0]}, {22'b0, 10'h200});
    check("acc_no_step", {30'b0, quad_a_o[0], quad_b_o[0]}, 32'h3);

    // Delta merged with a step: 3 - 5 - 1 = -3
    reset_dut();
    clk_en_i = 1'b1;
    cyc(3);
    clk_en_i = 1'b0;
    pulse0(8'd3);
    clk_en_i = 1'b1;
    pulse0(8'hFB);
    clk_en_i = 1'b0;
    check("merge_acc", {22'b0, dut.acc_q[0]}, {22'b0, 10'h3FD});
    check("merge_ab", {30'b0, quad_a_o[0], quad_b_o[0]}, 32'h1);

    // Reset during an interrupt pulse with acc nonzero
    reset_dut();
    clk_en_i = 1'b1;
    cyc(3);
    pulse0(8'd100);
    k = 0;
    while (spin_int_n_o !== 1'b0 && k < 20) begin
      cyc(1);
      k++;
    end
    check("int_seen", {31'b0, spin_int_n_o}, 32'h0);
    cyc(2);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_int", {31'b0, spin_int_n_o}, 32'h1);
    check("mid_rst_ab", {30'b0, quad_a_o[0], quad_b_o[0]}, 32'h3);
    check("mid_rst_acc", {22'b0, dut.acc_q[0]}, 32'h0);
    cyc(1);
    reset_n_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if ({quad_a_o[0], quad_b_o[0], spin_int_n_o} !== 3'b111) bad++;
    end
    check("post_rst_quiet", bad, 0);

    // First step after release waits the full SPIN_DIV ticks
    reset_n_i = 1'b0;
    cyc(1);
    reset_n_i = 1'b1;
    pulse0(8'd1);
    check("post_rst_tick1", {30'b0, quad_a_o[0], quad_b_o[0]}, 32'h3);
    cyc(1);
    check("post_rst_tick2", {30'b0, quad_a_o[0], quad_b_o[0]}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
